// File: rtl/wb_stage_pkg.sv
// Shared widths and types for the write-back stage slice.
//  DATA_W / ADDR_W / NUM_REGS : datapath and register file geometry
//  FLUSH_CNT_W                : width of the squash-window counter
//  RETIRE_MAX                 : saturation value of the retire counter
`timescale 1ns/1ps
package wb_stage_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned NUM_REGS    = 2 ** ADDR_W;
  localparam int unsigned FLUSH_CNT_W = 4;
  localparam int unsigned RETIRE_W    = 32;

  localparam logic [RETIRE_W-1:0] RETIRE_MAX = 32'hFFFF_FFFF;

  // Which operand supplies the redirect target, if any.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_RS   = 2'd2
  } redir_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM_WB -> WB bundle plus ID read ports and fetch redirect outputs.
//  master : the pipeline around the stage (drives MEM_WB fields and read indices)
//  slave  : wb_stage (returns read data, redirect, flush, retire count)
`timescale 1ns/1ps
interface wb_stage_if
  import wb_stage_pkg::*;
  ;

  logic [DATA_W-1:0]   data_in;
  logic [DATA_W-1:0]   alu_s_in;
  logic [DATA_W-1:0]   rs_in;
  logic [ADDR_W-1:0]   rd_in;
  logic                alu_flag_in;
  logic                mem_to_reg_in;
  logic                reg_write_in;
  logic                jump_mem_in;
  logic                jump_in;
  logic                branch_in;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                pc_redirect;
  logic [DATA_W-1:0]   pc_target;
  logic                flush;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    output data_in, alu_s_in, rs_in, rd_in, alu_flag_in, mem_to_reg_in,
           reg_write_in, jump_mem_in, jump_in, branch_in, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, pc_redirect, pc_target, flush, retire_count
  );

  modport slave (
    input  data_in, alu_s_in, rs_in, rd_in, alu_flag_in, mem_to_reg_in,
           reg_write_in, jump_mem_in, jump_in, branch_in, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, pc_redirect, pc_target, flush, retire_count
  );

endinterface

// File: rtl/wb_stage_reg_file.sv
// Architectural register file: 2 async read ports, 1 sync write port, sync reset.
//  clk, rst            : clock, synchronous active-high reset (clears every register)
//  we, wr_addr, wr_data: write port, committed at posedge
//  rd_addr_x/rd_data_x : combinational read ports
//  R0_ZERO             : register 0 reads as zero and ignores writes
`timescale 1ns/1ps
module wb_stage_reg_file
  import wb_stage_pkg::*;
#(
  parameter bit R0_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (we && !(R0_ZERO && wr_addr == '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Async reads.
  assign rd_data_a = (R0_ZERO && rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (R0_ZERO && rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register file, write-data select, same-cycle bypass to ID,
// control-transfer resolution into a registered PC redirect, and the squash
// window that discards wrong-path instructions draining behind a redirect.
//  clk, rst : clock, synchronous active-high reset
//  bus      : wb_stage_if.slave (MEM_WB fields in; ID read data, pc_redirect,
//             pc_target, flush, retire_count out)
//  FLUSH_DEPTH : instructions squashed after each redirect (1..15)
//  R0_ZERO     : register 0 hard-wired to zero
`timescale 1ns/1ps
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter bit          R0_ZERO     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   pc_redirect_q;
  logic [DATA_W-1:0]      pc_target_q;
  logic [RETIRE_W-1:0]    retire_q;

  logic                   squash_c;
  logic [DATA_W-1:0]      wb_data_c;
  logic                   commit_c;
  logic [DATA_W-1:0]      rf_data_a;
  logic [DATA_W-1:0]      rf_data_b;
  redir_src_e             redir_src_c;
  logic [DATA_W-1:0]      redir_target_c;
  logic                   take_c;

  assign squash_c  = (flush_cnt != '0);
  assign wb_data_c = bus.mem_to_reg_in ? bus.data_in : bus.alu_s_in;
  assign commit_c  = bus.reg_write_in && !squash_c && !(R0_ZERO && bus.rd_in == '0);

  wb_stage_reg_file #(.R0_ZERO(R0_ZERO)) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we        (commit_c),
    .wr_addr   (bus.rd_in),
    .wr_data   (wb_data_c),
    .rd_addr_a (bus.rd_addr_a),
    .rd_addr_b (bus.rd_addr_b),
    .rd_data_a (rf_data_a),
    .rd_data_b (rf_data_b)
  );

  // Same-cycle write->read bypass; register 0 masking is already applied in
  // the file, but a bypassed write to r0 cannot occur because commit_c excludes it.
  assign bus.rd_data_a = (commit_c && bus.rd_in == bus.rd_addr_a) ? wb_data_c : rf_data_a;
  assign bus.rd_data_b = (commit_c && bus.rd_in == bus.rd_addr_b) ? wb_data_c : rf_data_b;

  // Redirect priority: jump-via-memory > jump > taken branch; nothing while squashing.
  always_comb begin
    redir_src_c    = SRC_NONE;
    redir_target_c = bus.rs_in;
    if (!squash_c) begin
      if (bus.jump_mem_in) begin
        redir_src_c    = SRC_MEM;
        redir_target_c = bus.data_in;
      end else if (bus.jump_in || (bus.branch_in && bus.alu_flag_in)) begin
        redir_src_c    = SRC_RS;
        redir_target_c = bus.rs_in;
      end
    end
  end

  assign take_c = (redir_src_c != SRC_NONE);

  // Redirect pulse, target hold, squash window and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_redirect_q <= 1'b0;
      pc_target_q   <= '0;
      flush_cnt     <= '0;
      retire_q      <= '0;
    end else begin
      pc_redirect_q <= take_c;
      if (take_c) begin
        pc_target_q <= redir_target_c;
        flush_cnt   <= FLUSH_CNT_W'(FLUSH_DEPTH);
      end else if (squash_c) begin
        flush_cnt   <= flush_cnt - FLUSH_CNT_W'(1);
      end
      if (commit_c && retire_q != RETIRE_MAX) begin
        retire_q <= retire_q + RETIRE_W'(1);
      end
    end
  end

  assign bus.pc_redirect  = pc_redirect_q;
  assign bus.pc_target    = pc_target_q;
  assign bus.flush        = squash_c;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver applies one MEM_WB instruction per
// cycle, checks the combinational ID reads directly, and queues the expected
// post-edge outputs; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if bus();

  wb_stage #(.FLUSH_DEPTH(DEPTH), .R0_ZERO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic        redirect;
    logic [31:0] target;
    logic        flush;
    logic [31:0] retire;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  // Reference state: what the architecture should hold, not how the RTL stores it.
  logic [31:0] m_regs [64];
  int          m_squash_left;
  logic [31:0] m_target;
  logic [31:0] m_retire;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.data_in       = '0;
    bus.alu_s_in      = '0;
    bus.rs_in         = '0;
    bus.rd_in         = '0;
    bus.alu_flag_in   = 1'b0;
    bus.mem_to_reg_in = 1'b0;
    bus.reg_write_in  = 1'b0;
    bus.jump_mem_in   = 1'b0;
    bus.jump_in       = 1'b0;
    bus.branch_in     = 1'b0;
    bus.rd_addr_a     = '0;
    bus.rd_addr_b     = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_regs[i] = '0;
    m_squash_left = 0;
    m_target      = '0;
    m_retire      = '0;
  endtask

  // Apply the current inputs for one cycle and predict everything.
  task automatic tick();
    logic [31:0] wb;
    logic [31:0] tgt;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          sq;
    bit          commit;
    bit          take;
    exp_t        e;
    #1;
    sq     = (m_squash_left != 0);
    wb     = bus.mem_to_reg_in ? bus.data_in : bus.alu_s_in;
    commit = bus.reg_write_in && !sq;
    ea = (commit && bus.rd_in == bus.rd_addr_a) ? wb : m_regs[bus.rd_addr_a];
    eb = (commit && bus.rd_in == bus.rd_addr_b) ? wb : m_regs[bus.rd_addr_b];
    chk("rd_data_a", bus.rd_data_a, ea);
    chk("rd_data_b", bus.rd_data_b, eb);
    take = 1'b0;
    tgt  = '0;
    if (!sq) begin
      if (bus.jump_mem_in) begin
        take = 1'b1; tgt = bus.data_in;
      end else if (bus.jump_in) begin
        take = 1'b1; tgt = bus.rs_in;
      end else if (bus.branch_in && bus.alu_flag_in) begin
        take = 1'b1; tgt = bus.rs_in;
      end
    end
    if (rst) begin
      model_clear();
      e = '{cyc + 1, 1'b0, 32'h0, 1'b0, 32'h0};
    end else begin
      if (commit) begin
        m_regs[bus.rd_in] = wb;
        if (m_retire != 32'hFFFF_FFFF) m_retire = m_retire + 32'd1;
      end
      if (take) begin
        m_target      = tgt;
        m_squash_left = DEPTH;
      end else if (m_squash_left > 0) begin
        m_squash_left--;
      end
      e = '{cyc + 1, take, m_target, (m_squash_left != 0), m_retire};
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare registered outputs against the queued expectations.
  exp_t mon_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      chk("pc_redirect",  32'(bus.pc_redirect), 32'(mon_e.redirect));
      chk("pc_target",    bus.pc_target,        mon_e.target);
      chk("flush",        32'(bus.flush),       32'(mon_e.flush));
      chk("retire_count", bus.retire_count,     mon_e.retire);
    end
  end

  initial begin
    idle();
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset held for two cycles, then every index reads zero.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.rd_addr_a = 6'(i);
      bus.rd_addr_b = 6'(63 - i);
      tick();
    end

    // ALU write with same-cycle bypass, then readback from storage.
    bus.reg_write_in = 1'b1;
    bus.rd_in        = 6'd5;
    bus.alu_s_in     = 32'h1234;
    bus.data_in      = 32'hDEAD_BEEF;
    bus.rd_addr_a    = 6'd5;
    tick();
    idle();
    bus.rd_addr_a = 6'd5;
    tick();

    // Jump via memory; writes to r7 in the squash window must be dropped.
    bus.jump_mem_in = 1'b1;
    bus.data_in     = 32'h40;
    tick();
    idle();
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.reg_write_in = 1'b1;
      bus.rd_in        = 6'd7;
      bus.alu_s_in     = $urandom;
      bus.rd_addr_a    = 6'd7;
      tick();
    end
    idle();
    bus.rd_addr_a = 6'd7;
    tick();

    // Not-taken branch, then taken branch.
    bus.branch_in   = 1'b1;
    bus.alu_flag_in = 1'b0;
    bus.rs_in       = 32'h80;
    tick();
    bus.alu_flag_in = 1'b1;
    tick();
    idle();
    repeat (DEPTH + 1) tick();

    // Jump and jump-via-memory together: memory target wins, one pulse.
    bus.jump_in     = 1'b1;
    bus.jump_mem_in = 1'b1;
    bus.rs_in       = 32'h10;
    bus.data_in     = 32'h20;
    tick();
    idle();
    repeat (DEPTH + 1) tick();

    // Linked jump writes r9, then reset lands on the second squash cycle.
    bus.jump_in      = 1'b1;
    bus.rs_in        = 32'h300;
    bus.reg_write_in = 1'b1;
    bus.rd_in        = 6'd9;
    bus.alu_s_in     = 32'h55;
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rd_addr_a = 6'd5;
    bus.rd_addr_b = 6'd9;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      bus.data_in       = $urandom;
      bus.alu_s_in      = $urandom;
      bus.rs_in         = $urandom;
      bus.rd_in         = 6'($urandom_range(0, 15));
      bus.alu_flag_in   = 1'($urandom);
      bus.mem_to_reg_in = 1'($urandom);
      bus.reg_write_in  = ($urandom_range(0, 3) != 0);
      bus.jump_mem_in   = ($urandom_range(0, 15) == 0);
      bus.jump_in       = ($urandom_range(0, 15) == 0);
      bus.branch_in     = ($urandom_range(0, 7) == 0);
      bus.rd_addr_a     = 6'($urandom_range(0, 15));
      bus.rd_addr_b     = ($urandom_range(0, 3) == 0) ? bus.rd_in : 6'($urandom_range(0, 63));
      rst               = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
